// File: rtl/serial_addsub10.sv
// serial_addsub10 - bit-serial add/subtract unit.
//
// One fulladder is reused for WIDTH cycles, LSB first. A registered carry
// links each bit to the next one. Subtraction is done as A + ~B + 1: B is
// inverted when it is loaded, and the carry FF is preset to 1.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   start     request an operation (sampled only while not busy)
//   sub       0: A+B, 1: A-B (sampled with start)
//   A, B      operands (sampled with start)
//   busy      operation in progress
//   done      one-cycle pulse when result/cout/overflow update
//   result    sum/difference, held until the next completion
//   cout      carry out of the MSB (for sub, 1 = no borrow)
//   overflow  signed overflow (carry into MSB xor carry out of MSB)
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_IDLE  | waiting for start
// ST_RUN   | one bit per cycle through the fulladder
// ST_DONE  | result valid, done pulse; start here is accepted

module fulladder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_addsub10 #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] ra, rb;
   logic [WIDTH-2:0] racc;
   logic [WIDTH-1:0] racc_next;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_sum, fa_cout;
   logic             load, step, last;

   fulladder u_fa (
      .a    (ra[0]),
      .b    (rb[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // Accumulator plus this cycle's sum. On the last bit this is the full result.
   assign racc_next = {fa_sum, racc};
   assign last      = (cnt == CW'(WIDTH - 1));

   // busy and done are decoded straight from the state register, so they
   // have no combinational path from the inputs.
   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            step = 1'b1;
            if (last) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = ST_RUN;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ra       <= '0;
         rb       <= '0;
         racc     <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         result   <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else if (load) begin
         ra    <= A;
         rb    <= sub ? ~B : B;
         carry <= sub;
         cnt   <= '0;
         racc  <= '0;
      end else if (step) begin
         ra    <= ra >> 1;
         rb    <= rb >> 1;
         racc  <= racc_next[WIDTH-1:1];
         carry <= fa_cout;
         if (last) begin
            // The carry FF holds the carry into the MSB at this point.
            result   <= racc_next;
            cout     <= fa_cout;
            overflow <= carry ^ fa_cout;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: doc/serial_addsub10.md
# serial_addsub10

Bit-serial 10-bit add/subtract unit that time-multiplexes a single `fulladder` instance over WIDTH clock cycles, LSB first, with a registered carry flip-flop. It sits on the CPU datapath between the register-file read ports and the writeback mux. It provides an area-minimal ADD/SUB path with a start/busy/done handshake. It consumes the 1-bit `sum`/`cout` produced by `fulladder` each cycle and assembles the full-width result plus flags.

## Interface
- `WIDTH`, default 10: operand/result width in bits, at least 2.
- `clk`  input  1: rising-edge clock.
- `reset`  input  1: synchronous, active-high reset.
- `start`  input  1: request a new operation; sampled only when `busy`=0.
- `sub`  input  1: 0 = A+B, 1 = A−B (two's complement); sampled with `start`.
- `A`  input  WIDTH: operand A; sampled with `start`.
- `B`  input  WIDTH: operand B; sampled with `start`.
- `busy`  output  1: operation in progress.
- `done`  output  1: single-cycle pulse when the result is updated.
- `result`  output  WIDTH: sum/difference; holds its value until the next completion.
- `cout`  output  1: carry out of the MSB. For SUB, 1 means no borrow.
- `overflow`  output  1: signed overflow, equal to carry-in of the MSB XOR carry-out of the MSB.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE with `start`=1:
  - Latch A into shift register `ra`.
  - Latch B into `rb`, inverted when `sub`=1.
  - Set carry FF to `sub`.
  - Clear the bit counter.
  - Go to RUN.
- DONE with `start`=0: go to IDLE.
- RUN, each cycle:
  - `fulladder` inputs are A=`ra[0]`, B=`rb[0]`, cin=carry FF.
  - Shift `ra` and `rb` right by 1.
  - Shift `sum` into the MSB of the internal accumulator `racc` (shift right).
  - Carry FF takes `cout`.
  - Counter increments.
- RUN, on the cycle the counter equals WIDTH−1 (last bit):
  - `result` takes the final `racc` value, including this cycle's sum.
  - `cout` takes the adder `cout`.
  - `overflow` takes carry FF XOR adder `cout`. The carry FF at this point holds the carry into the MSB.
  - Go to DONE.
- `start` while `busy`=1 is ignored. Operands and `sub` are not re-sampled.
- The counter is sized to hold WIDTH−1 (4 bits for 10). It never wraps past WIDTH−1.
- Reset, including mid-operation:
  - State goes to IDLE.
  - `busy`=0, `done`=0, `result`=0, `cout`=0, `overflow`=0.
  - Internal registers and counter are cleared.
  - The in-flight operation is abandoned. No `done` is produced for it.
- `reset` and `start` high in the same cycle: `reset` wins.

## Timing
- Start accepted at edge T0 (`start`=1, `busy`=0). `busy`=1 from after T0 until after edge T0+WIDTH.
- Bits 0..WIDTH−1 are processed on edges T0+1 … T0+WIDTH.
- At edge T0+WIDTH:
  - `result`, `cout` and `overflow` update.
  - `done` goes 1 and `busy` goes 0.
- `done` is high for exactly one cycle: the cycle between edges T0+WIDTH and T0+WIDTH+1.
- Latency from start to result is WIDTH cycles (10). Throughput is one operation per WIDTH cycles.
- Back-to-back: `start`=1 in the DONE cycle is accepted. The next `done` follows WIDTH cycles later.
- `busy` and `done` are both registered. They are never high simultaneously.
- Outputs are stable (unchanged) throughout RUN.

## Test plan
- Reset, then A=5, B=3, `sub`=0 with a 1-cycle `start` -> `busy` for 10 cycles, `done` pulse at T0+10, `result`=8, `cout`=0, `overflow`=0.
- A=1023, B=1, `sub`=0 -> `result`=0, `cout`=1, `overflow`=0.
- A=511, B=1, `sub`=0 -> `result`=512, `cout`=0, `overflow`=1.
- A=5, B=7, `sub`=1 -> `result`=1022, `cout`=0 (borrow), `overflow`=0. Then A=7, B=5, `sub`=1 -> `result`=2, `cout`=1.
- Start A=5, B=3. At T0+3 pulse `start` with A=100, B=100 -> ignored. `done` at T0+10 with `result`=8. Then `start` in the DONE cycle with A=2, B=2 -> accepted, `done` 10 cycles later with `result`=4.
- Start A=1023, B=1, assert `reset` at T0+4 for 1 cycle -> all outputs 0, no `done` pulse, `busy`=0. A following start with A=1, B=1 -> `result`=2 after 10 cycles.
